// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: display reads always win, drawing (pixel RMW, fill) uses idle cycles.
// Ports: clk/rst_n, disp_* read path, wr_* pixel write, clr_* fill, ram_* single RAM port.
module fb_port_arbiter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        disp_req,
  input  logic [10:0] disp_addr,
  output logic [7:0]  disp_data,
  input  logic        wr_req,
  input  logic [6:0]  wr_x,
  input  logic [6:0]  wr_y,
  input  logic        wr_val,
  output logic        wr_ack,
  input  logic        clr_req,
  input  logic        clr_val,
  output logic        clr_busy,
  output logic        clr_done,
  output logic [10:0] ram_addr,
  output logic        ram_we,
  output logic [7:0]  ram_din,
  input  logic [7:0]  ram_dout
);

  typedef enum logic [2:0] {
    IDLE, RD, CAP, WR, CLR
  } state_t;

  state_t      state, state_n;
  logic [6:0]  lx, ly;
  logic        lval, clr_v;
  logic [7:0]  byte_q, cap_byte;
  logic [10:0] cnt, pix_addr, fsm_addr;
  logic [7:0]  fsm_din;
  logic        fsm_we, accept_clr, accept_wr;

  assign pix_addr  = {ly, lx[6:3]};
  assign disp_data = ram_dout;

  always_comb begin
    cap_byte = ram_dout;
    cap_byte[lx[2:0]] = lval;
  end

  always_comb begin
    state_n    = state;
    fsm_addr   = '0;
    fsm_we     = 1'b0;
    fsm_din    = '0;
    accept_clr = 1'b0;
    accept_wr  = 1'b0;
    unique case (state)
      IDLE: begin
        if (clr_req) begin
          accept_clr = 1'b1;
          state_n    = CLR;
        end else if (wr_req && !wr_ack) begin
          // wr_ack high means the requester is still dropping wr_req
          accept_wr = 1'b1;
          state_n   = RD;
        end
      end
      RD: begin
        fsm_addr = pix_addr;
        if (!disp_req) state_n = CAP;
      end
      // read data belongs to RD's read, so never stalls
      CAP: state_n = WR;
      WR: begin
        fsm_addr = pix_addr;
        fsm_we   = 1'b1;
        fsm_din  = byte_q;
        if (!disp_req) state_n = IDLE;
      end
      CLR: begin
        fsm_addr = cnt;
        fsm_we   = 1'b1;
        fsm_din  = {8{clr_v}};
        if (!disp_req && cnt == 11'h7FF)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    ram_addr = fsm_addr;
    ram_we   = fsm_we;
    ram_din  = fsm_din;
    if (disp_req) begin
      ram_addr = disp_addr;
      ram_we   = 1'b0;
      ram_din  = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      lx       <= '0;
      ly       <= '0;
      lval     <= 1'b0;
      clr_v    <= 1'b0;
      byte_q   <= '0;
      cnt      <= '0;
      wr_ack   <= 1'b0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state <= state_n;
      if (accept_clr) begin
        clr_v <= clr_val;
        cnt   <= '0;
      end else if (state == CLR && !disp_req) begin
        cnt <= cnt + 11'd1;
      end
      if (accept_wr) begin
        lx   <= wr_x;
        ly   <= wr_y;
        lval <= wr_val;
      end
      if (state == CAP) byte_q <= cap_byte;
      wr_ack   <= (state == WR) && !disp_req;
      clr_done <= (state == CLR) && !disp_req
                  && (cnt == 11'h7FF);
      clr_busy <= (state_n == CLR);
    end
  end

endmodule
